// File: rtl/alu_arbiter_ctrl.sv
// Round-robin arbiter that shares one combinational 32-bit ALU between two requesters,
// holding operands for multicycle ops and owning the architectural NZIV flag register.
module alu_arbiter_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req0_setf,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  input  logic        req1_setf,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [31:0] alu_val_A,
  output logic [31:0] alu_val_B,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic [31:0] alu_flags,
  output logic [3:0]  flags_q,
  output logic        busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;
  localparam logic [7:0] MUL_LAST = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] DIV_LAST = 8'(DIV_CYCLES - 1);

  logic [0:0]  state_r;
  logic        rr_last_r;
  logic        id_r;
  logic        setf_r;
  logic [7:0]  cnt_r;
  logic        grant_s;
  logic        grant_id_s;
  logic [31:0] sel_a_s;
  logic [31:0] sel_b_s;
  logic [2:0]  sel_op_s;
  logic        sel_setf_s;
  logic [7:0]  sel_last_s;
  logic        unused_flags_s;

  assign unused_flags_s = ^alu_flags[27:0];

  // Grant selection: a lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    grant_s    = 1'b0;
    grant_id_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_s    = 1'b1;
        grant_id_s = ~rr_last_r;
      end else if (req0_valid) begin
        grant_s    = 1'b1;
        grant_id_s = 1'b0;
      end else if (req1_valid) begin
        grant_s    = 1'b1;
        grant_id_s = 1'b1;
      end else begin
        grant_s    = 1'b0;
        grant_id_s = 1'b0;
      end
    end else begin
      grant_s    = 1'b0;
      grant_id_s = 1'b0;
    end
  end

  assign req0_ready = grant_s & ~grant_id_s;
  assign req1_ready = grant_s &  grant_id_s;
  assign busy       = (state_r == ST_EXEC);

  // Granted requester's fields and the hold count its opcode needs.
  always_comb begin
    sel_a_s    = grant_id_s ? req1_a    : req0_a;
    sel_b_s    = grant_id_s ? req1_b    : req0_b;
    sel_op_s   = grant_id_s ? req1_op   : req0_op;
    sel_setf_s = grant_id_s ? req1_setf : req0_setf;
    case (sel_op_s)
      3'b100:  sel_last_s = MUL_LAST;
      3'b101:  sel_last_s = DIV_LAST;
      default: sel_last_s = 8'd0;
    endcase
  end

  // Controller state: accept in IDLE, hold ALU inputs through EXEC, capture result on the last edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      rr_last_r  <= 1'b1;
      id_r       <= 1'b0;
      setf_r     <= 1'b0;
      cnt_r      <= 8'd0;
      alu_val_A  <= 32'd0;
      alu_val_B  <= 32'd0;
      alu_op     <= 3'b000;
      rsp_result <= 32'd0;
      rsp_flags  <= 4'd0;
      flags_q    <= 4'd0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            alu_val_A <= sel_a_s;
            alu_val_B <= sel_b_s;
            alu_op    <= sel_op_s;
            setf_r    <= sel_setf_s;
            id_r      <= grant_id_s;
            rr_last_r <= grant_id_s;
            cnt_r     <= sel_last_s;
            state_r   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_r != 8'd0) begin
            cnt_r <= cnt_r - 8'd1;
          end else begin
            rsp_result <= alu_out;
            rsp_flags  <= alu_flags[31:28];
            if (setf_r) begin
              flags_q <= alu_flags[31:28];
            end
            rsp0_valid <= ~id_r;
            rsp1_valid <= id_r;
            state_r    <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Directed bench for alu_arbiter_ctrl with a behavioural ALU model and hand-computed vectors.
module tb_alu_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic [2:0]  req0_op = 3'd0, req1_op = 3'd0;
  logic        req0_setf = 1'b0, req1_setf = 1'b0;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [31:0] alu_val_A, alu_val_B;
  logic [2:0]  alu_op;
  logic [31:0] alu_out;
  logic [31:0] alu_flags;
  logic [3:0]  flags_q;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter_ctrl #(.MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_setf(req0_setf),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_setf(req1_setf),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .alu_val_A(alu_val_A), .alu_val_B(alu_val_B), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flags(alu_flags), .flags_q(flags_q), .busy(busy)
  );

  // Behavioural ALU: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 DIV, 110 PASS A, 111 XOR
  logic [31:0]        m_res;
  logic               m_i, m_v;
  logic signed [63:0] m_prod;
  always_comb begin
    m_res  = 32'd0;
    m_i    = 1'b0;
    m_v    = 1'b0;
    m_prod = 64'sd0;
    case (alu_op)
      3'b000: begin
        m_res = alu_val_A + alu_val_B;
        m_v   = (alu_val_A[31] == alu_val_B[31]) && (m_res[31] != alu_val_A[31]);
      end
      3'b001: begin
        m_res = alu_val_A - alu_val_B;
        m_v   = (alu_val_A[31] != alu_val_B[31]) && (m_res[31] != alu_val_A[31]);
      end
      3'b010: m_res = alu_val_A & alu_val_B;
      3'b011: m_res = alu_val_A | alu_val_B;
      3'b100: begin
        m_prod = $signed({{32{alu_val_A[31]}}, alu_val_A}) * $signed({{32{alu_val_B[31]}}, alu_val_B});
        m_res  = m_prod[31:0];
        m_v    = (m_prod != $signed({{32{m_prod[31]}}, m_prod[31:0]}));
      end
      3'b101: begin
        if (alu_val_B == 32'd0) begin
          m_res = 32'd0;
          m_i   = 1'b1;
        end else begin
          m_res = $signed(alu_val_A) / $signed(alu_val_B);
        end
      end
      3'b110:  m_res = alu_val_A;
      default: m_res = alu_val_A ^ alu_val_B;
    endcase
  end
  assign alu_out   = m_res;
  assign alu_flags = {m_res[31], (m_res == 32'd0), m_i, m_v, 28'h0};

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        setf;
    logic [31:0] res;
    logic [3:0]  fl;
    logic [3:0]  fq;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One single-requester transaction: request, accept, wait for pulse, check everything.
  task automatic run_op(input vec_t v);
    int  k;
    bit  seen;
    @(negedge clk);
    if (v.id == 1'b0) begin
      req0_a = v.a; req0_b = v.b; req0_op = v.op; req0_setf = v.setf; req0_valid = 1'b1;
    end else begin
      req1_a = v.a; req1_b = v.b; req1_op = v.op; req1_setf = v.setf; req1_valid = 1'b1;
    end
    #1;
    chk("ready", {30'd0, req1_ready, req0_ready}, v.id ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("alu_a_latched", alu_val_A, v.a);
    chk("alu_b_latched", alu_val_B, v.b);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      if (rsp0_valid || rsp1_valid) begin
        seen = 1'b1;
      end else begin
        chk("alu_op_held", {29'd0, alu_op}, {29'd0, v.op});
        chk("busy_exec", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        k++;
      end
    end
    chk("latency", seen ? k : 99, v.lat);
    chk("rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, v.id ? 32'd2 : 32'd1);
    chk("rsp_result", rsp_result, v.res);
    chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, v.fl});
    chk("flags_q", {28'd0, flags_q}, {28'd0, v.fq});
    chk("busy_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("rsp_single_cycle", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        exp_id;
    logic [31:0] exp_res;
    int          n0, n1;
    bit          seen;

    vecs[0] = '{1'b0, 32'd5,          32'd7,          3'b000, 1'b1, 32'd12,         4'b0000, 4'b0000, 1};
    vecs[1] = '{1'b0, 32'hFFFF_FFFD,  32'd4,          3'b100, 1'b1, 32'hFFFF_FFF4,  4'b1000, 4'b1000, 2};
    vecs[2] = '{1'b1, 32'd1,          32'd1,          3'b001, 1'b0, 32'd0,          4'b0100, 4'b1000, 1};
    vecs[3] = '{1'b1, 32'd10,         32'd0,          3'b101, 1'b1, 32'd0,          4'b0110, 4'b0110, 4};
    vecs[4] = '{1'b0, 32'h7FFF_FFFF,  32'd1,          3'b000, 1'b1, 32'h8000_0000,  4'b1001, 4'b1001, 1};
    vecs[5] = '{1'b1, 32'hF0F0_F0F0,  32'hFFFF_FFFF,  3'b111, 1'b1, 32'h0F0F_0F0F,  4'b0000, 4'b0000, 1};
    vecs[6] = '{1'b0, 32'hFFFF_FFEC,  32'd3,          3'b101, 1'b0, 32'hFFFF_FFFA,  4'b1000, 4'b0000, 4};
    vecs[7] = '{1'b1, 32'h0000_00FF,  32'h0000_0F00,  3'b010, 1'b1, 32'd0,          4'b0100, 4'b0100, 1};

    // Reset state
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flags_q", {28'd0, flags_q}, 32'd0);
    chk("rst_alu_a", alu_val_A, 32'd0);
    chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
    chk("rst_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i]);
    end

    // Both requesters valid continuously: grants must alternate starting with req0.
    @(negedge clk);
    req0_a = 32'd10;  req0_b = 32'd1; req0_op = 3'b000; req0_setf = 1'b0; req0_valid = 1'b1;
    req1_a = 32'd200; req1_b = 32'd2; req1_op = 3'b000; req1_setf = 1'b0; req1_valid = 1'b1;
    #1;
    n0 = 0;
    n1 = 0;
    for (int g = 0; g < 8; g++) begin
      exp_id  = g[0];
      exp_res = exp_id ? (req1_a + 32'd2) : (req0_a + 32'd1);
      chk("rr_grant", {30'd0, req1_ready, req0_ready}, exp_id ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      chk("rr_busy_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      if (exp_id == 1'b0) begin
        n0++;
        if (n0 == 4) req0_valid = 1'b0; else req0_a = 32'd10 + 32'(n0);
      end else begin
        n1++;
        if (n1 == 4) req1_valid = 1'b0; else req1_a = 32'd200 + 32'(n1);
      end
      @(posedge clk); #1;
      chk("rr_rsp", {30'd0, rsp1_valid, rsp0_valid}, exp_id ? 32'd2 : 32'd1);
      chk("rr_result", rsp_result, exp_res);
    end
    chk("rr_flags_q_kept", {28'd0, flags_q}, 32'd4);

    // Reset in the middle of a DIV discards it.
    @(negedge clk);
    req1_a = 32'd10; req1_b = 32'd0; req1_op = 3'b101; req1_setf = 1'b1; req1_valid = 1'b1;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_flags_q", {28'd0, flags_q}, 32'd0);
    chk("mid_rst_alu_op", {29'd0, alu_op}, 32'd0);
    chk("mid_rst_alu_a", alu_val_A, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (rsp0_valid || rsp1_valid) seen = 1'b1;
    end
    chk("mid_no_rsp", {31'd0, seen}, 32'd0);
    chk("mid_flags_q_after", {28'd0, flags_q}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("post_rst_tie_req0", {30'd0, req1_ready, req0_ready}, 32'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    run_op(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
